uart_rx: RTL

UART receiver: deserializes a line-coded frame on `RX_IN` (start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, stop bit 1) into a parallel word. It uses an oversampling clock `CLK` running at Prescale × baud. It is the receive-side counterpart of the UART transmit path in the same UART block and shares its frame format and parity conventions. It reports each word with a one-cycle valid pulse and flags parity and stop-bit errors.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserializer with 2-of-3
// mid-bit majority voting, parity/stop error pulses and a debug state output.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic [2:0]            dbg_state_o
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q;
   logic [5:0]            edge_cnt_q;
   logic [5:0]            prescale_q;
   logic [BW-1:0]         bit_cnt_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_fail_q;
   logic [1:0]            smp_q;
   logic [DATA_WIDTH-1:0] shift_q;

   logic [5:0] half;
   logic       last_edge;
   logic       at_mid;
   logic       maj;

   // Third vote is the live line value at the mid-bit edge itself.
   assign half      = {1'b0, prescale_q[5:1]};
   assign last_edge = (edge_cnt_q == prescale_q - 6'd1);
   assign at_mid    = (edge_cnt_q == half);
   assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);

   assign dbg_state_o = state_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         edge_cnt_q <= '0;
         prescale_q <= '0;
         bit_cnt_q  <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_fail_q <= 1'b0;
         smp_q      <= '0;
         shift_q    <= '0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         if (state_q != IDLE) begin
            if (edge_cnt_q == half - 6'd2) smp_q[0] <= RX_IN;
            if (edge_cnt_q == half - 6'd1) smp_q[1] <= RX_IN;
            edge_cnt_q <= last_edge ? 6'd0 : edge_cnt_q + 6'd1;
         end

         case (state_q)
            IDLE: begin
               edge_cnt_q <= '0;
               bit_cnt_q  <= '0;
               par_fail_q <= 1'b0;
               // The detecting cycle is edge 0, so the count resumes at 1.
               if (!RX_IN) begin
                  state_q    <= START;
                  edge_cnt_q <= 6'd1;
                  prescale_q <= Prescale;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
               end
            end
            START: begin
               if (at_mid && maj) begin
                  state_q    <= IDLE;
                  edge_cnt_q <= '0;
               end else if (last_edge) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (at_mid)
                  shift_q <= (shift_q >> 1) | (DATA_WIDTH'(maj) << (DATA_WIDTH - 1));
               if (last_edge) begin
                  if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                     bit_cnt_q <= '0;
                     state_q   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (at_mid) par_fail_q <= (maj != ((^shift_q) ^ par_typ_q));
               if (last_edge) state_q <= STOP;
            end
            STOP: begin
               // Decide mid-stop-bit so a back-to-back start edge is never missed.
               if (at_mid) begin
                  stp_err    <= ~maj;
                  par_err    <= par_fail_q;
                  if (maj && !par_fail_q) begin
                     P_DATA     <= shift_q;
                     data_valid <= 1'b1;
                  end
                  state_q    <= IDLE;
                  edge_cnt_q <= '0;
                  par_fail_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               edge_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule
